// File: rtl/nrzi_encode.sv
// NRZI line encoder for the USB transmit path: encodes the stuffed bitstream onto dp/dm,
// appends the SE0/J end-of-packet sequence and returns the bus to idle J.
module nrzi_encode #(
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_bit,
  input  logic bs_sending,
  output logic dp,
  output logic dm,
  output logic nrzi_sending,
  output logic nrzi_ready,
  output logic eop_done,
  output logic overlap_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_EOP_SE0 = 2'd2,
    ST_EOP_J   = 2'd3
  } state_t;

  localparam logic [3:0] SE0_LAST = 4'(EOP_SE0_BITS);

  state_t     r_state;
  logic       r_level;
  logic [3:0] r_se0_cnt;
  logic       r_dp;
  logic       r_dm;
  logic       r_sending;
  logic       r_ready;
  logic       r_eop;
  logic       r_ovl;

  state_t     w_state;
  logic       w_level;
  logic [3:0] w_se0_cnt;
  logic       w_dp;
  logic       w_dm;
  logic       w_sending;
  logic       w_ready;
  logic       w_eop;
  logic       w_ovl;
  logic       w_base;
  logic       w_enc;

  // Next-state and next-output logic; every EOP cycle still runs even if data reappears.
  always_comb begin
    w_state   = r_state;
    w_level   = r_level;
    w_se0_cnt = r_se0_cnt;
    w_dp      = 1'b1;
    w_dm      = 1'b0;
    w_sending = r_sending;
    w_eop     = 1'b0;
    w_ovl     = 1'b0;
    w_base    = (r_state == ST_IDLE) ? 1'b1 : r_level;
    w_enc     = in_bit ? w_base : ~w_base;

    case (r_state)
      ST_IDLE: begin
        if (bs_sending) begin
          w_level   = w_enc;
          w_dp      = w_enc;
          w_dm      = ~w_enc;
          w_sending = 1'b1;
          w_state   = ST_SEND;
        end else begin
          w_level   = 1'b1;
          w_sending = 1'b0;
        end
      end
      ST_SEND: begin
        if (bs_sending) begin
          w_level = w_enc;
          w_dp    = w_enc;
          w_dm    = ~w_enc;
        end else begin
          w_dp      = 1'b0;
          w_dm      = 1'b0;
          w_se0_cnt = 4'd1;
          w_state   = ST_EOP_SE0;
        end
      end
      ST_EOP_SE0: begin
        w_ovl = bs_sending;
        if (r_se0_cnt < SE0_LAST) begin
          w_dp      = 1'b0;
          w_dm      = 1'b0;
          w_se0_cnt = r_se0_cnt + 4'd1;
        end else begin
          w_eop   = 1'b1;
          w_state = ST_EOP_J;
        end
      end
      ST_EOP_J: begin
        w_ovl     = bs_sending;
        w_sending = 1'b0;
        w_level   = 1'b1;
        w_state   = ST_IDLE;
      end
      default: begin
        w_sending = 1'b0;
        w_level   = 1'b1;
        w_state   = ST_IDLE;
      end
    endcase

    w_ready = (w_state == ST_IDLE);
  end

  // State and registered outputs; reset forces the line to J at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_level   <= 1'b1;
      r_se0_cnt <= 4'd0;
      r_dp      <= 1'b1;
      r_dm      <= 1'b0;
      r_sending <= 1'b0;
      r_ready   <= 1'b1;
      r_eop     <= 1'b0;
      r_ovl     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_level   <= w_level;
      r_se0_cnt <= w_se0_cnt;
      r_dp      <= w_dp;
      r_dm      <= w_dm;
      r_sending <= w_sending;
      r_ready   <= w_ready;
      r_eop     <= w_eop;
      r_ovl     <= w_ovl;
    end
  end

  assign dp           = r_dp;
  assign dm           = r_dm;
  assign nrzi_sending = r_sending;
  assign nrzi_ready   = r_ready;
  assign eop_done     = r_eop;
  assign overlap_err  = r_ovl;

endmodule

// File: tb/tb_nrzi_encode.sv
// Self-checking bench for nrzi_encode: vector table, hand sequences, and random traffic
// against a packet-level reference model (output vector = {dp,dm,sending,ready,eop,ovl}).
module tb_nrzi_encode;

  localparam int NR = 400;
  localparam logic [5:0] IDLE_OUT = 6'b100100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_bit = 1'b0;
  logic bs = 1'b0;

  logic dp2, dm2, snd2, rdy2, eop2, ovl2;
  logic dp3, dm3, snd3, rdy3, eop3, ovl3;
  logic [5:0] o2, o3;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic       bs;
    logic       bit_v;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];

  logic       rnd_bs[NR];
  logic       rnd_bit[NR];
  logic [5:0] exp_tmp[NR];
  logic [5:0] exp2[NR];
  logic [5:0] exp3[NR];

  always #5 clk = ~clk;

  nrzi_encode #(.EOP_SE0_BITS(2)) dut (
    .clock(clk), .reset_n(rst_n), .in_bit(in_bit), .bs_sending(bs),
    .dp(dp2), .dm(dm2), .nrzi_sending(snd2), .nrzi_ready(rdy2),
    .eop_done(eop2), .overlap_err(ovl2)
  );

  nrzi_encode #(.EOP_SE0_BITS(3)) dut3 (
    .clock(clk), .reset_n(rst_n), .in_bit(in_bit), .bs_sending(bs),
    .dp(dp3), .dm(dm3), .nrzi_sending(snd3), .nrzi_ready(rdy3),
    .eop_done(eop3), .overlap_err(ovl3)
  );

  assign o2 = {dp2, dm2, snd2, rdy2, eop2, ovl2};
  assign o3 = {dp3, dm3, snd3, rdy3, eop3, ovl3};

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (dp,dm,snd,rdy,eop,ovl) at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bs = 1'b0;
    in_bit = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", o2, IDLE_OUT);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic b, input logic d, input logic [5:0] e);
    vec_t v;
    v.bs = b;
    v.bit_v = d;
    v.exp = e;
    return v;
  endfunction

  // Packet-level model: each run of bs=1 is one packet, followed by nse0 SE0 bit-times,
  // one J bit with eop, and one turnaround cycle; bs=1 after the packet end is dropped.
  task automatic build_model(input int nse0);
    int i;
    int k;
    logic lvl;
    for (int c = 0; c < NR; c++) exp_tmp[c] = IDLE_OUT;
    i = 0;
    while (i < NR) begin
      if (!rnd_bs[i]) begin
        i++;
        continue;
      end
      lvl = 1'b1;
      k = i;
      while (k < NR && rnd_bs[k]) begin
        lvl = rnd_bit[k] ? lvl : ~lvl;
        exp_tmp[k] = {lvl, ~lvl, 4'b1000};
        k++;
      end
      for (int c = k; c < k + nse0 && c < NR; c++)
        exp_tmp[c] = {5'b00100, (c > k) ? rnd_bs[c] : 1'b0};
      if (k + nse0 < NR)
        exp_tmp[k + nse0] = {5'b10101, rnd_bs[k + nse0]};
      if (k + nse0 + 1 < NR)
        exp_tmp[k + nse0 + 1] = {5'b10010, rnd_bs[k + nse0 + 1]};
      i = k + nse0 + 2;
    end
  endtask

  initial begin
    logic [5:0] seq5[6];

    // idle
    for (int j = 0; j < 5; j++) tbl.push_back(mk(1'b0, 1'b0, IDLE_OUT));
    // packet 1,0,0,1
    tbl.push_back(mk(1'b1, 1'b1, 6'b101000));
    tbl.push_back(mk(1'b1, 1'b0, 6'b011000));
    tbl.push_back(mk(1'b1, 1'b0, 6'b101000));
    tbl.push_back(mk(1'b1, 1'b1, 6'b101000));
    tbl.push_back(mk(1'b0, 1'b0, 6'b001000));
    tbl.push_back(mk(1'b0, 1'b0, 6'b001000));
    tbl.push_back(mk(1'b0, 1'b0, 6'b101010));
    tbl.push_back(mk(1'b0, 1'b0, IDLE_OUT));
    tbl.push_back(mk(1'b0, 1'b0, IDLE_OUT));
    // seven zeros toggle every bit
    for (int j = 0; j < 7; j++)
      tbl.push_back(mk(1'b1, 1'b0, (j % 2 == 0) ? 6'b011000 : 6'b101000));
    tbl.push_back(mk(1'b0, 1'b0, 6'b001000));
    tbl.push_back(mk(1'b0, 1'b0, 6'b001000));
    tbl.push_back(mk(1'b0, 1'b0, 6'b101010));
    tbl.push_back(mk(1'b0, 1'b0, IDLE_OUT));
    // overlap: bs back high one cycle after falling
    tbl.push_back(mk(1'b1, 1'b1, 6'b101000));
    tbl.push_back(mk(1'b1, 1'b0, 6'b011000));
    tbl.push_back(mk(1'b0, 1'b0, 6'b001000));
    tbl.push_back(mk(1'b1, 1'b1, 6'b001001));
    tbl.push_back(mk(1'b1, 1'b1, 6'b101011));
    tbl.push_back(mk(1'b1, 1'b1, 6'b100101));
    tbl.push_back(mk(1'b1, 1'b0, 6'b011000));
    tbl.push_back(mk(1'b0, 1'b0, 6'b001000));
    tbl.push_back(mk(1'b0, 1'b0, 6'b001000));
    tbl.push_back(mk(1'b0, 1'b0, 6'b101010));
    tbl.push_back(mk(1'b0, 1'b0, IDLE_OUT));

    do_reset();
    foreach (tbl[j]) begin
      bs = tbl[j].bs;
      in_bit = tbl[j].bit_v;
      step();
      chk($sformatf("table[%0d]", j), o2, tbl[j].exp);
    end

    // 1-bit packet with three SE0 bit-times
    do_reset();
    seq5[0] = 6'b101000;
    seq5[1] = 6'b001000;
    seq5[2] = 6'b001000;
    seq5[3] = 6'b001000;
    seq5[4] = 6'b101010;
    seq5[5] = IDLE_OUT;
    for (int j = 0; j < 6; j++) begin
      bs = (j == 0);
      in_bit = 1'b1;
      step();
      chk($sformatf("se0x3[%0d]", j), o3, seq5[j]);
    end

    // reset during the second SE0 bit-time
    do_reset();
    bs = 1'b1;
    in_bit = 1'b1;
    step();
    chk("rst_mid_bit", o2, 6'b101000);
    bs = 1'b0;
    step();
    chk("rst_mid_se0a", o2, 6'b001000);
    step();
    chk("rst_mid_se0b", o2, 6'b001000);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", o2, IDLE_OUT);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bs = 1'b1;
    in_bit = 1'b0;
    step();
    chk("rst_restart", o2, 6'b011000);
    bs = 1'b0;
    repeat (6) step();

    // random traffic against the model, both EOP lengths at once
    for (int c = 0; c < NR; c++) begin
      rnd_bs[c] = ($urandom_range(0, 9) < 7);
      rnd_bit[c] = 1'($urandom_range(0, 1));
    end
    build_model(2);
    exp2 = exp_tmp;
    build_model(3);
    exp3 = exp_tmp;
    do_reset();
    for (int c = 0; c < NR; c++) begin
      bs = rnd_bs[c];
      in_bit = rnd_bit[c];
      step();
      chk($sformatf("rand2[%0d]", c), o2, exp2[c]);
      chk($sformatf("rand3[%0d]", c), o3, exp3[c]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
